// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the sequential ALU.
// Select fields, logic opcodes, FSM states and flag indices.
package alu_pkg;

  localparam int SEL_MUL   = 4;
  localparam int SEL_LOGIC = 3;

  localparam logic [1:0] LOP_AND = 2'b00;
  localparam logic [1:0] LOP_OR  = 2'b01;
  localparam logic [1:0] LOP_XOR = 2'b10;
  localparam logic [1:0] LOP_NOT = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int F_C = 3;
  localparam int F_Z = 2;
  localparam int F_N = 1;
  localparam int F_V = 0;

endpackage

// File: rtl/alu_core_n.sv
// alu_core_n: combinational arithmetic/logic unit.
// Ripple adder with carry-into-MSB tap, logic unit, flags.
module alu_core_n
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       select,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flg
);

  logic [WIDTH-1:0] bp;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] lres;

  // Operand B' and bitwise ripple carry chain
  always_comb begin
    bp   = ({WIDTH{select[2]}} & ~y)
         | ({WIDTH{select[1]}} & y);
    c    = '0;
    sum  = '0;
    c[0] = select[0];
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]  = x[i] ^ bp[i] ^ c[i];
      c[i+1]  = (x[i] & bp[i])
              | (x[i] & c[i])
              | (bp[i] & c[i]);
    end
  end

  // Logic unit; select[2] plays no part here
  always_comb begin
    lres = '0;
    case (select[1:0])
      LOP_AND: lres = x & y;
      LOP_OR:  lres = x | y;
      LOP_XOR: lres = x ^ y;
      LOP_NOT: lres = ~x;
      default: lres = '0;
    endcase
  end

  // Result mux and flags
  always_comb begin
    flg = '0;
    if (select[SEL_LOGIC]) begin
      res = lres;
    end else begin
      res      = sum;
      flg[F_C] = c[WIDTH];
      flg[F_V] = c[WIDTH-1] ^ c[WIDTH];
    end
    flg[F_Z] = (res == '0);
    flg[F_N] = res[WIDTH-1];
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes.
// Single-cycle ALU ops and a WIDTH-step shift-add multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [4:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [3:0]       flags
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  logic             accept;
  logic             xfer;
  logic             is_mul;
  logic             mul_last;

  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  logic [WIDTH-1:0] core_res;
  logic [3:0]       core_flg;

  alu_core_n #(
    .WIDTH (WIDTH)
  ) u_core (
    .x      (x),
    .y      (y),
    .select (select[3:0]),
    .res    (core_res),
    .flg    (core_flg)
  );

  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;
  assign is_mul   = select[SEL_MUL];
  assign mul_last = (state == ST_MUL)
                  && (cnt == CNT_W'(1));

  // One shift-add step over {acc, mplier}
  always_comb begin
    step_sum = {1'b0, acc}
             + (mplier[0] ? {1'b0, mcand}
                          : '0);
    step_hi  = step_sum[WIDTH:1];
    step_lo  = {step_sum[0],
                mplier[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept && is_mul)
                 state_nx = ST_MUL;
      ST_MUL:  if (mul_last)
                 state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Handshake output: busy in MUL or while a result is held
  always_comb begin
    in_ready = (state == ST_IDLE)
             && (!out_valid || out_ready);
  end

  // Multiply operand, accumulator and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (accept && is_mul) begin
      cnt    <= CNT_W'(WIDTH);
      mcand  <= x;
      mplier <= y;
      acc    <= '0;
    end else if (state == ST_MUL) begin
      cnt    <= cnt - CNT_W'(1);
      acc    <= step_hi;
      mplier <= step_lo;
    end
  end

  // Result registers and output valid
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_hi    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else if (accept && !is_mul) begin
      out       <= core_res;
      out_hi    <= '0;
      flags     <= core_flg;
      out_valid <= 1'b1;
    end else if (mul_last) begin
      out            <= step_lo;
      out_hi         <= step_hi;
      flags          <= '0;
      flags[F_C]     <= (step_hi != '0);
      flags[F_Z]     <= (step_lo == '0);
      flags[F_N]     <= step_lo[WIDTH-1];
      out_valid      <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule
